// File: rtl/stack_bus_pkg.sv
// rtl/stack_bus_pkg.sv - shared controller-bus geometry and responder state encoding
package stack_bus_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 128;

  localparam logic [DATA_W-1:0] CLEAR_VAL = 8'h00;

  typedef logic [0:0] state_t;

  localparam state_t CLEAR = 1'b0;
  localparam state_t IDLE  = 1'b1;

endpackage

// File: rtl/ram_128x8_sync.sv
// rtl/ram_128x8_sync.sv - raw synchronous store: one write port, one registered read port
module ram_128x8_sync
  import stack_bus_pkg::*;
#(
  parameter int ADDR_W = stack_bus_pkg::ADDR_W,
  parameter int DATA_W = stack_bus_pkg::DATA_W,
  parameter int DEPTH  = stack_bus_pkg::DEPTH
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array deliberately unreset; the responder's clear sequence initialises it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_mem_responder.sv
// rtl/stack_mem_responder.sv - controller-bus memory responder with self-clear after reset
module stack_mem_responder
  import stack_bus_pkg::*;
#(
  parameter int                ADDR_W    = stack_bus_pkg::ADDR_W,
  parameter int                DATA_W    = stack_bus_pkg::DATA_W,
  parameter int                DEPTH     = stack_bus_pkg::DEPTH,
  parameter logic [DATA_W-1:0] CLEAR_VAL = stack_bus_pkg::CLEAR_VAL
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              req_rd;
  logic              req_wr;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  always_comb begin
    req_wr    = (state_q == IDLE) && cs && we;
    req_rd    = (state_q == IDLE) && cs && !we;
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;

    // Clear path owns the write port; bus requests are dropped while clearing.
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = CLEAR_VAL;
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == LAST_PTR) begin
        state_d = IDLE;
      end
    end else if (req_wr) begin
      mem_we = 1'b1;
    end

    mem_we     = mem_we && !RESET;
    mem_re     = req_rd && !RESET;
    rd_valid_d = req_rd;
    hold_d     = rd_valid_q ? mem_rdata : hold_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      rd_valid_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rd_valid_q <= rd_valid_d;
      hold_q     <= hold_d;
    end
  end

  ram_128x8_sync #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (addr),
    .rdata_o (mem_rdata)
  );

  // Fresh read data is visible in its valid cycle; otherwise the last read value is held.
  assign data_out = rd_valid_q ? mem_rdata : hold_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_stack_mem_responder.sv
// tb/tb_stack_mem_responder.sv - scoreboard bench for stack_mem_responder with a word-array model
module tb_stack_mem_responder;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mem_model [128];
  logic [7:0] exp_q [$];
  logic [7:0] last_exp = 8'h00;
  int         clear_left = 128;
  logic       reset_seen = 1'b0;
  logic       checking_en = 1'b0;

  stack_mem_responder dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model of the clear sequence: 128 busy cycles after each reset edge.
  always @(posedge CLK) begin
    reset_seen <= RESET;
    if (RESET) begin
      clear_left  <= 128;
      checking_en <= 1'b1;
    end else if (clear_left > 0) begin
      clear_left <= clear_left - 1;
    end
  end

  // Monitor: samples on the falling edge, pops expected read data on each rd_valid.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (checking_en) begin
        if (reset_seen) begin
          chk("reset_rd_valid", rd_valid, 0);
          chk("reset_data_out", data_out, 8'h00);
          chk("reset_busy", busy, 1);
          exp_q.delete();
          last_exp = 8'h00;
        end else begin
          chk("busy", busy, (clear_left != 0));
          if (rd_valid) begin
            if (exp_q.size() == 0) begin
              chk("spurious_rd_valid", rd_valid, 0);
            end else begin
              e = exp_q.pop_front();
              chk("read_data", data_out, e);
              last_exp = e;
            end
          end else begin
            chk("data_out_hold", data_out, last_exp);
          end
        end
      end
    end
  end

  task automatic step(input logic c, input logic w, input logic [6:0] a, input logic [7:0] d);
    @(posedge CLK);
    #1;
    RESET   = 1'b0;
    cs      = c;
    we      = w;
    addr    = a;
    data_in = d;
    if (c && clear_left == 0) begin
      if (w) mem_model[a] = d;
      else   exp_q.push_back(mem_model[a]);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 7'd0, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    cs    = 1'b0;
    we    = 1'b0;
    for (int i = 0; i < 128; i++) mem_model[i] = 8'h00;
  endtask

  task automatic wait_clear();
    for (int i = 0; i < 300 && busy; i++) idle();
    chk("clear_done", busy, 0);
  endtask

  initial begin
    int busy_cycles;
    int op;
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int busy_cycles;
    int op;
    for (int i = 0; i < 128; i++) mem_model[i] = 8'h00;

    // Reset, then measure the clear length.
    do_reset();
    busy_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      idle();
      if (!busy) break;
      busy_cycles++;
    end
    chk("clear_length", busy_cycles, 128);
    step(1, 0, 7'd0, 0);
    step(1, 0, 7'd64, 0);
    step(1, 0, 7'd127, 0);
    idle();

    // Read after write on consecutive cycles.
    step(1, 1, 7'd7, 8'hA5);
    step(1, 0, 7'd7, 0);
    idle();

    // Back-to-back reads.
    step(1, 1, 7'd0, 8'h11);
    step(1, 1, 7'd1, 8'h22);
    step(1, 1, 7'd2, 8'h33);
    step(1, 0, 7'd0, 0);
    step(1, 0, 7'd1, 0);
    step(1, 0, 7'd2, 0);
    idle();

    // Reset right behind a read.
    step(1, 1, 7'd3, 8'h5A);
    step(1, 0, 7'd3, 0);
    do_reset();

    // Write attempt during clear (cycle 20) must be dropped.
    for (int i = 0; i < 19; i++) idle();
    step(1, 1, 7'd5, 8'hFF);
    step(1, 0, 7'd5, 0);
    wait_clear();
    step(1, 0, 7'd5, 0);
    step(1, 0, 7'd3, 0);
    idle();

    // Data hold across idle cycles.
    step(1, 1, 7'd9, 8'h42);
    step(1, 0, 7'd9, 0);
    for (int i = 0; i < 10; i++) idle();

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 199);
      if (op == 0) do_reset();
      else if (op < 40) idle();
      else if (op < 110) step(1, 1, 7'($urandom_range(0, 127)), 8'($urandom));
      else step(1, 0, 7'($urandom_range(0, 127)), 0);
    end
    wait_clear();
    for (int i = 0; i < 4; i++) idle();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
